// File: rtl/uart_frame_host_pkg.sv
// uart_frame_host_pkg: shared state encoding, length-width helper and checksum combiner
package uart_frame_host_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_RECV, ST_DONE} state_e;
  localparam int CSUM_MAX_W = 64;
  function automatic int len_w(input int max_bytes);
    return $clog2(max_bytes + 1);
  endfunction
  function automatic logic [CSUM_MAX_W-1:0] csum_xor(input logic [CSUM_MAX_W-1:0] acc, input logic [CSUM_MAX_W-1:0] data);
    return acc ^ data;
  endfunction
endpackage

// File: rtl/uart_frame_timer.sv
// uart_frame_timer: clearable saturating idle counter, expired_o at TIMEOUT_CYCLES_P-1
module uart_frame_timer #(
  parameter int TIMEOUT_CYCLES_P = 65535,
  localparam int W = $clog2(TIMEOUT_CYCLES_P)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);
  logic [W-1:0] cnt_q;
  assign expired_o = cnt_q == W'(TIMEOUT_CYCLES_P - 1);
  always_ff @(posedge clk)
    if (rst || clr_i) cnt_q <= '0;
    else if (en_i && !expired_o) cnt_q <= cnt_q + W'(1);
endmodule

// File: rtl/uart_frame_host.sv
// uart_frame_host: sends a command frame to a uart tx stream and collects a timed response.
// Optional XOR checksum byte on both directions when UART_FRAME_HOST_CHECKSUM_EN is defined.
module uart_frame_host
  import uart_frame_host_pkg::*;
#(
  parameter int DATA_WIDTH_P = 8,
  parameter int MAX_BYTES_P = 8,
  parameter int TIMEOUT_CYCLES_P = 65535,
  localparam int LEN_W = len_w(MAX_BYTES_P),
  localparam int BUF_W = MAX_BYTES_P * DATA_WIDTH_P
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  input  logic [LEN_W-1:0]        cmd_tx_len_i,
  input  logic [LEN_W-1:0]        cmd_rx_len_i,
  input  logic [BUF_W-1:0]        cmd_data_i,
  output logic [DATA_WIDTH_P-1:0] tx_tdata_o,
  output logic                    tx_tvalid_o,
  input  logic                    tx_tready_i,
  input  logic [DATA_WIDTH_P-1:0] rx_tdata_i,
  input  logic                    rx_tvalid_i,
  output logic                    rx_tready_o,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [BUF_W-1:0]        rsp_data_o,
  output logic [LEN_W-1:0]        rsp_count_o,
  output logic                    rsp_timeout_o,
  output logic                    rsp_csum_err_o,
  output logic                    busy_o
);
`ifdef UART_FRAME_HOST_CHECKSUM_EN
  localparam logic CSUM = 1'b1;
`else
  localparam logic CSUM = 1'b0;
`endif
  localparam int LW1 = LEN_W + 1;
  localparam logic [1:0] IDLE = ST_IDLE, SEND = ST_SEND, RECV = ST_RECV, DONE = ST_DONE;
  logic [1:0] state, state_n;
  logic rdy_q, tmo_q, err_q, expired;
  logic [LEN_W-1:0] tx_len_q, rx_len_q, idx_q, cnt_q, tx_c, rx_c;
  logic [BUF_W-1:0] cmd_q, rsp_q;
  logic [DATA_WIDTH_P-1:0] csum_q, tx_byte;
  logic cmd_fire, tx_fire, rx_fire, tx_last, rx_is_csum, rx_last, tmo_fire;
  assign tx_c = cmd_tx_len_i > LEN_W'(MAX_BYTES_P) ? LEN_W'(MAX_BYTES_P) : cmd_tx_len_i;
  assign rx_c = cmd_rx_len_i > LEN_W'(MAX_BYTES_P) ? LEN_W'(MAX_BYTES_P) : cmd_rx_len_i;
  assign cmd_fire = cmd_valid_i & rdy_q;
  assign tx_fire = (state == SEND) & tx_tready_i;
  assign rx_fire = (state == RECV) & rx_tvalid_i;
  // With checksum the frame carries one trailing byte beyond the payload length
  assign tx_last = LW1'(idx_q) + LW1'(1) == LW1'(tx_len_q) + LW1'(CSUM);
  assign rx_is_csum = CSUM & (cnt_q == rx_len_q);
  assign rx_last = rx_is_csum | (~CSUM & (LW1'(cnt_q) + LW1'(1) == LW1'(rx_len_q)));
  assign tmo_fire = (state == RECV) & ~rx_fire & expired;
  assign tx_byte = DATA_WIDTH_P'(cmd_q >> (int'(idx_q) * DATA_WIDTH_P));
  assign state_n = state == IDLE ? (cmd_fire ? ((|tx_c | CSUM) ? SEND : (|rx_c ? RECV : DONE)) : IDLE)
                 : state == SEND ? ((tx_fire && tx_last) ? ((|rx_len_q | CSUM) ? RECV : DONE) : SEND)
                 : state == RECV ? (((rx_fire && rx_last) || tmo_fire) ? DONE : RECV)
                 : (rsp_ready_i ? IDLE : DONE);
  assign cmd_ready_o = rdy_q;
  assign busy_o = state != IDLE;
  assign tx_tvalid_o = state == SEND;
  assign tx_tdata_o = (CSUM && idx_q == tx_len_q) ? csum_q : tx_byte;
  assign rx_tready_o = state == RECV;
  assign rsp_valid_o = state == DONE;
  assign rsp_data_o = rsp_q;
  assign rsp_count_o = cnt_q;
  assign rsp_timeout_o = tmo_q;
  assign rsp_csum_err_o = CSUM & err_q;
  uart_frame_timer #(.TIMEOUT_CYCLES_P(TIMEOUT_CYCLES_P)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clr_i    ((state != RECV) | rx_fire),
    .en_i     (state == RECV),
    .expired_o(expired)
  );
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      rdy_q <= 1'b0;
      tx_len_q <= '0;
      rx_len_q <= '0;
      idx_q <= '0;
      cnt_q <= '0;
      cmd_q <= '0;
      rsp_q <= '0;
      csum_q <= '0;
      tmo_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state <= state_n;
      rdy_q <= state_n == IDLE;
      if (cmd_fire) begin
        tx_len_q <= tx_c;
        rx_len_q <= rx_c;
        cmd_q <= cmd_data_i;
        idx_q <= '0;
        cnt_q <= '0;
        rsp_q <= '0;
        csum_q <= '0;
        tmo_q <= 1'b0;
        err_q <= 1'b0;
      end
      // Accumulator restarts after the last tx beat so it can check the response
      if (tx_fire) begin
        idx_q <= idx_q + LEN_W'(1);
        csum_q <= tx_last ? '0 : DATA_WIDTH_P'(csum_xor(CSUM_MAX_W'(csum_q), CSUM_MAX_W'(tx_tdata_o)));
      end
      if (rx_fire && !rx_is_csum) begin
        rsp_q <= rsp_q | (BUF_W'(rx_tdata_i) << (int'(cnt_q) * DATA_WIDTH_P));
        cnt_q <= cnt_q + LEN_W'(1);
        csum_q <= DATA_WIDTH_P'(csum_xor(CSUM_MAX_W'(csum_q), CSUM_MAX_W'(rx_tdata_i)));
      end
      if (rx_fire && rx_is_csum) err_q <= rx_tdata_i != csum_q;
      if (tmo_fire) begin
        tmo_q <= 1'b1;
        err_q <= CSUM;
      end
    end
endmodule

// File: tb/tb_uart_frame_host.sv
// tb_uart_frame_host: directed frame, back-pressure, timeout, zero-length, reset and checksum steps
module tb_uart_frame_host;
  logic clk = 1'b0;
  logic rst, cmd_valid, cmd_ready, tx_tvalid, tx_tready, rx_tvalid, rx_tready;
  logic rsp_valid, rsp_ready, rsp_timeout, rsp_csum_err, busy;
  logic [3:0] tx_len, rx_len, rsp_count;
  logic [63:0] cmd_data, rsp_data;
  logic [7:0] tx_tdata, rx_tdata;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  uart_frame_host #(.DATA_WIDTH_P(8), .MAX_BYTES_P(8), .TIMEOUT_CYCLES_P(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_valid_i   (cmd_valid),
    .cmd_ready_o   (cmd_ready),
    .cmd_tx_len_i  (tx_len),
    .cmd_rx_len_i  (rx_len),
    .cmd_data_i    (cmd_data),
    .tx_tdata_o    (tx_tdata),
    .tx_tvalid_o   (tx_tvalid),
    .tx_tready_i   (tx_tready),
    .rx_tdata_i    (rx_tdata),
    .rx_tvalid_i   (rx_tvalid),
    .rx_tready_o   (rx_tready),
    .rsp_valid_o   (rsp_valid),
    .rsp_ready_i   (rsp_ready),
    .rsp_data_o    (rsp_data),
    .rsp_count_o   (rsp_count),
    .rsp_timeout_o (rsp_timeout),
    .rsp_csum_err_o(rsp_csum_err),
    .busy_o        (busy)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic [3:0] t, input logic [3:0] r, input logic [63:0] d);
    chk("cmd_ready_before_issue", cmd_ready, 1'b1);
    cmd_valid = 1'b1;
    tx_len = t;
    rx_len = r;
    cmd_data = d;
    step();
    cmd_valid = 1'b0;
  endtask
  task automatic release_rsp();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("cmd_ready_after_rsp", cmd_ready, 1'b1);
  endtask
  initial begin
    rst = 1'b1;
    cmd_valid = 1'b0;
    tx_len = '0;
    rx_len = '0;
    cmd_data = '0;
    tx_tready = 1'b0;
    rx_tvalid = 1'b0;
    rx_tdata = '0;
    rsp_ready = 1'b0;
    step();
    step();
    chk("rst_cmd_ready", cmd_ready, 1'b0);
    chk("rst_outputs", {busy, tx_tvalid, rx_tready, rsp_valid, rsp_timeout, rsp_csum_err}, 6'b0);
    chk("rst_rsp", {rsp_data, rsp_count, tx_tdata}, 76'h0);
    rst = 1'b0;
    step();
    chk("post_rst_cmd_ready", cmd_ready, 1'b1);
`ifndef UART_FRAME_HOST_CHECKSUM_EN
    tx_tready = 1'b1;
    issue(4'd3, 4'd2, 64'h070501);
    chk("basic_b0", {tx_tvalid, tx_tdata}, 9'h101);
    chk("basic_busy", {busy, cmd_ready}, 2'b10);
    step();
    chk("basic_b1", {tx_tvalid, tx_tdata}, 9'h105);
    step();
    chk("basic_b2", {tx_tvalid, tx_tdata}, 9'h107);
    step();
    chk("basic_recv", {tx_tvalid, rx_tready}, 2'b01);
    rx_tvalid = 1'b1;
    rx_tdata = 8'h0C;
    step();
    rx_tdata = 8'h00;
    step();
    rx_tvalid = 1'b0;
    chk("basic_valid", {rsp_valid, rx_tready}, 2'b10);
    chk("basic_data", rsp_data, 64'h000C);
    chk("basic_count", rsp_count, 4'd2);
    chk("basic_flags", {rsp_timeout, rsp_csum_err}, 2'b00);
    release_rsp();
    issue(4'd4, 4'd0, 64'h44332211);
    chk("bp_b0", tx_tdata, 8'h11);
    step();
    chk("bp_b1", tx_tdata, 8'h22);
    tx_tready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bp_hold", {tx_tvalid, tx_tdata}, 9'h122);
    end
    tx_tready = 1'b1;
    step();
    chk("bp_b2", tx_tdata, 8'h33);
    step();
    chk("bp_b3", tx_tdata, 8'h44);
    step();
    chk("bp_done", {rsp_valid, tx_tvalid, rsp_count}, 6'b100000);
    release_rsp();
    issue(4'd0, 4'd4, 64'h0);
    chk("tmo_recv", rx_tready, 1'b1);
    rx_tvalid = 1'b1;
    rx_tdata = 8'hAA;
    step();
    rx_tvalid = 1'b0;
    for (int i = 0; i < 15; i++) step();
    chk("tmo_not_yet", rsp_valid, 1'b0);
    step();
    chk("tmo_valid", rsp_valid, 1'b1);
    chk("tmo_flags", {rsp_timeout, rsp_csum_err}, 2'b10);
    chk("tmo_count", rsp_count, 4'd1);
    chk("tmo_data", rsp_data, 64'hAA);
    release_rsp();
    issue(4'd0, 4'd0, 64'h0);
    chk("zero_valid", {rsp_valid, tx_tvalid, rx_tready}, 3'b100);
    chk("zero_rsp", {rsp_count, rsp_timeout, rsp_data}, 69'h0);
    release_rsp();
    issue(4'd0, 4'd3, 64'h0);
    rx_tvalid = 1'b1;
    rx_tdata = 8'h5A;
    step();
    rx_tvalid = 1'b0;
    step();
    chk("mid_partial", {rx_tready, rsp_count}, 5'h11);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_ctrl", {cmd_ready, busy, tx_tvalid, rx_tready, rsp_valid, rsp_timeout, rsp_csum_err}, 7'b0);
    chk("mid_rst_rsp", {rsp_data, rsp_count}, 68'h0);
    step();
    chk("mid_rst_ready", cmd_ready, 1'b1);
    issue(4'd1, 4'd1, 64'h99);
    chk("mid_new_tx", {tx_tvalid, tx_tdata}, 9'h199);
    step();
    rx_tvalid = 1'b1;
    rx_tdata = 8'h3C;
    step();
    rx_tvalid = 1'b0;
    chk("mid_new_rsp", {rsp_valid, rsp_timeout, rsp_count, rsp_data}, {2'b10, 4'd1, 64'h3C});
    release_rsp();
    issue(4'd9, 4'd0, 64'h0807060504030201);
    for (int i = 0; i < 7; i++) step();
    chk("clamp_last", {tx_tvalid, tx_tdata}, 9'h108);
    step();
    chk("clamp_done", {rsp_valid, tx_tvalid}, 2'b10);
    release_rsp();
`else
    tx_tready = 1'b1;
    issue(4'd2, 4'd2, 64'h3412);
    chk("cs_b0", tx_tdata, 8'h12);
    step();
    chk("cs_b1", tx_tdata, 8'h34);
    step();
    chk("cs_sum", {tx_tvalid, tx_tdata}, 9'h126);
    step();
    chk("cs_recv", rx_tready, 1'b1);
    rx_tvalid = 1'b1;
    rx_tdata = 8'h0F;
    step();
    rx_tdata = 8'hF0;
    step();
    rx_tdata = 8'hFF;
    step();
    rx_tvalid = 1'b0;
    chk("cs_ok", {rsp_valid, rsp_csum_err, rsp_timeout, rsp_count}, 7'b1000010);
    chk("cs_ok_data", rsp_data, 64'hF00F);
    release_rsp();
    issue(4'd2, 4'd2, 64'h3412);
    step();
    step();
    step();
    rx_tvalid = 1'b1;
    rx_tdata = 8'h0F;
    step();
    rx_tdata = 8'hF0;
    step();
    rx_tdata = 8'h00;
    step();
    rx_tvalid = 1'b0;
    chk("cs_bad", {rsp_valid, rsp_csum_err, rsp_count}, 6'b110010);
    chk("cs_bad_data", rsp_data, 64'hF00F);
    release_rsp();
    issue(4'd0, 4'd0, 64'h0);
    chk("cs_zero_sum", {tx_tvalid, tx_tdata}, 9'h100);
    step();
    rx_tvalid = 1'b1;
    rx_tdata = 8'h00;
    step();
    rx_tvalid = 1'b0;
    chk("cs_zero_ok", {rsp_valid, rsp_csum_err, rsp_count}, 6'b100000);
    release_rsp();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
